// File: rtl/mem_io_responder_if.sv
// CPU memory bus and UART byte streams between a CPU/UART pair and mem_io_responder.
interface mem_io_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        program_done;

    modport slave (
        input  rdy_in, mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
        output mem_din, io_buffer_full, rx_ready, tx_valid, tx_data, program_done
    );

    modport master (
        output rdy_in, mem_a, mem_wr, mem_dout, rx_valid, rx_data, tx_ready,
        input  mem_din, io_buffer_full, rx_ready, tx_valid, tx_data, program_done
    );
endinterface

// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus memory-mapped UART RX/TX, cycle counter and program-stop flag.
module mem_io_responder #(
    parameter int unsigned RAM_AW  = 17,
    parameter int unsigned TXQ_LOG = 4
) (
    input logic               clk_in,
    input logic               rst_in,
    mem_io_responder_if.slave bus
);
    localparam int unsigned      Depth     = 1 << TXQ_LOG;
    localparam logic [TXQ_LOG:0] DepthLvl  = (TXQ_LOG + 1)'(Depth);
    localparam logic [TXQ_LOG:0] FullLvl   = (TXQ_LOG + 1)'(Depth - 2);
    localparam logic [TXQ_LOG:0] LvlOne    = (TXQ_LOG + 1)'(1);
    localparam logic [TXQ_LOG-1:0] PtrOne  = TXQ_LOG'(1);

    logic              w_acc, w_rd, w_wr, w_io, w_unused;
    logic [15:0]       w_off;
    logic [RAM_AW-1:0] w_idx;

    // Reset outranks any request presented in the same cycle.
    assign w_acc    = bus.rdy_in && !rst_in;
    assign w_rd     = w_acc && !bus.mem_wr;
    assign w_wr     = w_acc && bus.mem_wr;
    assign w_io     = (bus.mem_a[17:16] == 2'b11);
    assign w_off    = bus.mem_a[15:0];
    assign w_idx    = bus.mem_a[RAM_AW-1:0];
    assign w_unused = ^bus.mem_a[31:18];

    logic [7:0] r_ram [1 << RAM_AW];
    logic [7:0] r_ram_rd;

    always_ff @(posedge clk_in) begin
        if (w_wr && !w_io) r_ram[w_idx] <= bus.mem_dout;
        if (w_rd && !w_io) r_ram_rd <= r_ram[w_idx];
    end

    logic        r_src_ram, r_done;
    logic [7:0]  r_io_din, w_io_din_d;
    logic [31:0] r_cnt, r_snap;
    logic        w_rx_rd;

    always_comb begin
        w_io_din_d = 8'h00;
        case (w_off)
            16'h0000: w_io_din_d = bus.rx_valid ? bus.rx_data : 8'h00;
            16'h0004: w_io_din_d = r_cnt[7:0];
            16'h0005: w_io_din_d = r_snap[15:8];
            16'h0006: w_io_din_d = r_snap[23:16];
            16'h0007: w_io_din_d = r_snap[31:24];
            default:  w_io_din_d = 8'h00;
        endcase
    end

    assign w_rx_rd      = w_rd && w_io && (w_off == 16'h0000);
    assign bus.rx_ready = w_rx_rd && bus.rx_valid;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_src_ram <= 1'b0;
            r_io_din  <= 8'h00;
            r_cnt     <= 32'd0;
            r_snap    <= 32'd0;
            r_done    <= 1'b0;
        end else begin
            if (bus.rdy_in) r_cnt <= r_cnt + 32'd1;
            if (w_rd) begin
                r_src_ram <= !w_io;
                if (w_io) r_io_din <= w_io_din_d;
                if (w_io && (w_off == 16'h0004)) r_snap <= r_cnt;
            end
            if (w_wr && w_io && (w_off == 16'h0004)) r_done <= 1'b1;
        end
    end

    // mem_din holds: RAM read data and IO data each only update on their own reads.
    assign bus.mem_din      = r_src_ram ? r_ram_rd : r_io_din;
    assign bus.program_done = r_done;

    logic [7:0]         r_txq [Depth];
    logic [TXQ_LOG-1:0] r_wp, r_rp;
    logic [TXQ_LOG:0]   r_level, w_level_d;
    logic               r_full;
    logic               w_push_req, w_push, w_pop;
    logic [7:0]         w_push_data;

    // Program stop pushes a literal 0x00, which the data write path filters out.
    assign w_push_req  = w_wr && w_io &&
                         (((w_off == 16'h0000) && (bus.mem_dout != 8'h00)) ||
                          (w_off == 16'h0004));
    assign w_push_data = (w_off == 16'h0004) ? 8'h00 : bus.mem_dout;
    assign w_pop       = (r_level != '0) && bus.tx_ready;
    assign w_push      = w_push_req && ((r_level != DepthLvl) || w_pop);

    always_comb begin
        w_level_d = r_level;
        if (w_push && !w_pop)      w_level_d = r_level + LvlOne;
        else if (w_pop && !w_push) w_level_d = r_level - LvlOne;
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_txq[r_wp] <= w_push_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + PtrOne;
            if (w_pop)  r_rp <= r_rp + PtrOne;
            r_level <= w_level_d;
            r_full  <= (w_level_d >= FullLvl);
        end
    end

    assign bus.tx_valid       = (r_level != '0);
    assign bus.tx_data        = r_txq[r_rp];
    assign bus.io_buffer_full = r_full;
endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read data and TX bytes are checked against queues.
module tb_mem_io_responder;
    logic       clk_in = 1'b0;
    logic       rst_in;
    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_din_q [$];
    logic [7:0] exp_tx_q [$];
    logic [7:0] mon_exp;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_AW (17),
        .TXQ_LOG(4)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    // TX monitor: a byte leaves the FIFO at the next edge whenever valid and ready.
    always @(negedge clk_in) begin
        if (!rst_in && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            n_checks++;
            if (exp_tx_q.size() == 0) begin
                n_fails++;
                $display("FAIL tx_unexpected: got %02h, expected no byte", bus.tx_data);
            end else begin
                mon_exp = exp_tx_q.pop_front();
                if (bus.tx_data !== mon_exp) begin
                    n_fails++;
                    $display("FAIL tx_data: got %02h, expected %02h", bus.tx_data, mon_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in   = 1'b1;
        bus.mem_wr   = wr;
        bus.mem_a    = a;
        bus.mem_dout = d;
    endtask

    task automatic set_idle();
        drive(1'b0, 32'h0003_0008, 8'h00);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        set_idle();
        step();
        step();
        rst_in = 1'b0;
        exp_tx_q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst_in = 1'b1;
        drive(1'b1, 32'h0003_0000, 8'h55);
        step();
        step();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h66;
        drive(1'b0, 32'h0003_0000, 8'h00);
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fails++; $display("FAIL reset_rx_ready: got %b, expected 0", bus.rx_ready);
        end
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fails++; $display("FAIL reset_mem_din: got %02h, expected 00", bus.mem_din);
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_tx_valid: got %b, expected 0", bus.tx_valid);
        end
        n_checks++;
        if (bus.io_buffer_full !== 1'b0) begin
            n_fails++; $display("FAIL reset_full: got %b, expected 0", bus.io_buffer_full);
        end
        n_checks++;
        if (bus.program_done !== 1'b0) begin
            n_fails++; $display("FAIL reset_done: got %b, expected 0", bus.program_done);
        end
        rst_in = 1'b0;
        bus.rx_valid = 1'b0;
        set_idle();
        repeat (5) step();
        drive(1'b0, 32'h0003_0004, 8'h00);
        exp_din_q.push_back(8'd5);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL reset_counter: got %02h, expected %02h", bus.mem_din, e);
        end
    endtask

    task automatic test_ram();
        logic [7:0] e;
        drive(1'b1, 32'h0000_0010, 8'hA5);
        step();
        drive(1'b0, 32'h0000_0010, 8'h00);
        exp_din_q.push_back(8'hA5);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL ram_raw: got %02h, expected %02h", bus.mem_din, e);
        end
        drive(1'b1, 32'h0000_0020, 8'h3C);
        step();
        n_checks++;
        if (bus.mem_din !== 8'hA5) begin
            n_fails++; $display("FAIL ram_hold_on_write: got %02h, expected a5", bus.mem_din);
        end
        drive(1'b0, 32'h0000_0020, 8'h00);
        bus.rdy_in = 1'b0;
        step();
        n_checks++;
        if (bus.mem_din !== 8'hA5) begin
            n_fails++; $display("FAIL ram_paused_read: got %02h, expected a5", bus.mem_din);
        end
        drive(1'b1, 32'h0000_0010, 8'h77);
        bus.rdy_in = 1'b0;
        step();
        // 0x20010 and 0xFFFC0010 both decode to RAM index 0x10.
        drive(1'b0, 32'h0002_0010, 8'h00);
        exp_din_q.push_back(8'hA5);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL ram_alias: got %02h, expected %02h", bus.mem_din, e);
        end
        drive(1'b0, 32'hFFFC_0010, 8'h00);
        exp_din_q.push_back(8'hA5);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL ram_high_bits: got %02h, expected %02h", bus.mem_din, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [6] = '{32'h0_0000, 32'h0_0001, 32'h0_FFFF,
                                   32'h1_FFFF, 32'h1_2345, 32'h0_0100};
        logic [7:0]  datas [6] = '{8'h5A, 8'hC3, 8'h01, 8'hFE, 8'h80, 8'h7F};
        logic [7:0]  e;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, addrs[i], datas[i]);
            step();
        end
        for (int i = 5; i >= 0; i--) begin
            drive(1'b0, addrs[i], 8'h00);
            exp_din_q.push_back(datas[i]);
            step();
            e = exp_din_q.pop_front();
            n_checks++;
            if (bus.mem_din !== e) begin
                n_fails++;
                $display("FAIL b2b_read[%0d]: got %02h, expected %02h", i, bus.mem_din, e);
            end
        end
        set_idle();
    endtask

    task automatic test_io_other();
        logic [31:0] addrs [3] = '{32'h0003_0008, 32'h0003_FFFF, 32'h0003_0001};
        logic [7:0]  e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0000_0010, 8'h00);
            step();
            drive(1'b0, addrs[i], 8'h00);
            exp_din_q.push_back(8'h00);
            step();
            e = exp_din_q.pop_front();
            n_checks++;
            if (bus.mem_din !== e) begin
                n_fails++;
                $display("FAIL io_other_read[%0d]: got %02h, expected %02h", i, bus.mem_din, e);
            end
        end
        bus.tx_ready = 1'b0;
        drive(1'b1, 32'h0003_0010, 8'h99);
        step();
        drive(1'b1, 32'h0003_0001, 8'h99);
        step();
        set_idle();
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fails++; $display("FAIL io_other_write: got tx_valid %b, expected 0", bus.tx_valid);
        end
    endtask

    task automatic test_tx_filter();
        int k;
        bus.tx_ready = 1'b1;
        drive(1'b1, 32'h0003_0000, 8'h41);
        exp_tx_q.push_back(8'h41);
        step();
        drive(1'b1, 32'h0003_0000, 8'h00);
        step();
        drive(1'b1, 32'h0003_0000, 8'h42);
        exp_tx_q.push_back(8'h42);
        step();
        set_idle();
        k = 0;
        while (bus.tx_valid === 1'b1 && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || exp_tx_q.size() != 0) begin
            n_fails++;
            $display("FAIL tx_filter_drain: got tx_valid %b pending %0d, expected 0 and 0",
                     bus.tx_valid, exp_tx_q.size());
        end
    endtask

    task automatic test_fifo_full();
        int k;
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            drive(1'b1, 32'h0003_0000, 8'(i));
            exp_tx_q.push_back(8'(i));
            step();
            if (i == 13) begin
                n_checks++;
                if (bus.io_buffer_full !== 1'b0) begin
                    n_fails++;
                    $display("FAIL full_at_13: got %b, expected 0", bus.io_buffer_full);
                end
            end
        end
        n_checks++;
        if (bus.io_buffer_full !== 1'b1) begin
            n_fails++; $display("FAIL full_at_14: got %b, expected 1", bus.io_buffer_full);
        end
        for (int i = 15; i <= 16; i++) begin
            drive(1'b1, 32'h0003_0000, 8'(i));
            exp_tx_q.push_back(8'(i));
            step();
        end
        drive(1'b1, 32'h0003_0000, 8'h11);
        step();
        bus.tx_ready = 1'b1;
        drive(1'b1, 32'h0003_0000, 8'h12);
        exp_tx_q.push_back(8'h12);
        step();
        set_idle();
        // Level is 16 here; the flag must hold through two pops and drop on the third.
        step();
        step();
        n_checks++;
        if (bus.io_buffer_full !== 1'b1) begin
            n_fails++; $display("FAIL full_after_2_pops: got %b, expected 1", bus.io_buffer_full);
        end
        step();
        n_checks++;
        if (bus.io_buffer_full !== 1'b0) begin
            n_fails++; $display("FAIL full_after_3_pops: got %b, expected 0", bus.io_buffer_full);
        end
        k = 0;
        while (bus.tx_valid === 1'b1 && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || exp_tx_q.size() != 0) begin
            n_fails++;
            $display("FAIL fifo_full_drain: got tx_valid %b pending %0d, expected 0 and 0",
                     bus.tx_valid, exp_tx_q.size());
        end
    endtask

    task automatic test_rx();
        logic [7:0] e;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h37;
        drive(1'b0, 32'h0003_0000, 8'h00);
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b1) begin
            n_fails++; $display("FAIL rx_ready_on_read: got %b, expected 1", bus.rx_ready);
        end
        exp_din_q.push_back(8'h37);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL rx_data: got %02h, expected %02h", bus.mem_din, e);
        end
        set_idle();
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fails++; $display("FAIL rx_ready_idle: got %b, expected 0", bus.rx_ready);
        end
        drive(1'b0, 32'h0003_0000, 8'h00);
        bus.rdy_in = 1'b0;
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fails++; $display("FAIL rx_ready_paused: got %b, expected 0", bus.rx_ready);
        end
        step();
        n_checks++;
        if (bus.mem_din !== 8'h37) begin
            n_fails++; $display("FAIL rx_paused_hold: got %02h, expected 37", bus.mem_din);
        end
        bus.rx_valid = 1'b0;
        drive(1'b0, 32'h0003_0000, 8'h00);
        #1;
        n_checks++;
        if (bus.rx_ready !== 1'b0) begin
            n_fails++; $display("FAIL rx_ready_empty: got %b, expected 0", bus.rx_ready);
        end
        exp_din_q.push_back(8'h00);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL rx_empty_data: got %02h, expected %02h", bus.mem_din, e);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hC8;
        exp_din_q.push_back(8'hC8);
        step();
        e = exp_din_q.pop_front();
        n_checks++;
        if (bus.mem_din !== e) begin
            n_fails++; $display("FAIL rx_second: got %02h, expected %02h", bus.mem_din, e);
        end
        bus.rx_valid = 1'b0;
        set_idle();
    endtask

    task automatic test_counter();
        logic [31:0] a_seq [6] = '{32'h3_0004, 32'h3_0005, 32'h3_0006, 32'h3_0007,
                                   32'h3_0004, 32'h3_0005};
        logic [7:0]  d_seq [6] = '{8'h2C, 8'h01, 8'h00, 8'h00, 8'h30, 8'h01};
        logic [7:0]  e;
        do_reset();
        repeat (150) step();
        bus.rdy_in = 1'b0;
        repeat (7) step();
        set_idle();
        repeat (150) step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, a_seq[i], 8'h00);
            exp_din_q.push_back(d_seq[i]);
            step();
            e = exp_din_q.pop_front();
            n_checks++;
            if (bus.mem_din !== e) begin
                n_fails++;
                $display("FAIL counter_read[%0d]: got %02h, expected %02h", i, bus.mem_din, e);
            end
        end
        set_idle();
    endtask

    task automatic test_program_done();
        int k;
        n_checks++;
        if (bus.program_done !== 1'b0) begin
            n_fails++; $display("FAIL done_initial: got %b, expected 0", bus.program_done);
        end
        bus.tx_ready = 1'b1;
        drive(1'b1, 32'h0003_0004, 8'hFF);
        exp_tx_q.push_back(8'h00);
        step();
        set_idle();
        n_checks++;
        if (bus.program_done !== 1'b1) begin
            n_fails++; $display("FAIL done_set: got %b, expected 1", bus.program_done);
        end
        k = 0;
        while (bus.tx_valid === 1'b1 && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || exp_tx_q.size() != 0) begin
            n_fails++;
            $display("FAIL done_zero_emitted: got tx_valid %b pending %0d, expected 0 and 0",
                     bus.tx_valid, exp_tx_q.size());
        end
        repeat (3) step();
        n_checks++;
        if (bus.program_done !== 1'b1) begin
            n_fails++; $display("FAIL done_sticky: got %b, expected 1", bus.program_done);
        end
        bus.tx_ready = 1'b0;
        drive(1'b1, 32'h0003_0000, 8'h99);
        step();
        drive(1'b1, 32'h0003_0000, 8'h98);
        step();
        n_checks++;
        if (bus.tx_valid !== 1'b1) begin
            n_fails++; $display("FAIL done_queued: got %b, expected 1", bus.tx_valid);
        end
        do_reset();
        n_checks++;
        if (bus.program_done !== 1'b0) begin
            n_fails++; $display("FAIL done_cleared: got %b, expected 0", bus.program_done);
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fails++; $display("FAIL done_fifo_cleared: got %b, expected 0", bus.tx_valid);
        end
        bus.tx_ready = 1'b1;
        step();
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fails++; $display("FAIL done_fifo_stays_empty: got %b, expected 0", bus.tx_valid);
        end
    endtask

    initial begin
        rst_in       = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        set_idle();
        test_reset();
        test_ram();
        test_back_to_back();
        test_io_other();
        test_tx_filter();
        test_fifo_full();
        test_rx();
        test_counter();
        test_program_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_AW, default 17, RAM byte-address width (128 KB).
REQ-002 Parameter TXQ_LOG, default 4, log2 of UART TX FIFO depth.
REQ-003 clk_in  input  1  system clock; the block has one clock.
REQ-004 rst_in  input  1  reset; synchronous, active-high.
REQ-005 rdy_in  input  1  CPU ready; low = CPU paused, requests ignored.
REQ-006 mem_a  input  32  CPU address bus; bits 17:0 decoded.
REQ-007 mem_wr  input  1  1 = write, 0 = read.
REQ-008 mem_dout  input  8  CPU write data.
REQ-009 mem_din  output  8  read data returned to CPU.
REQ-010 io_buffer_full  output  1  TX FIFO nearly full; CPU must not write 0x30000.
REQ-011 rx_valid  input  1  UART RX byte available.
REQ-012 rx_data  input  8  UART RX byte.
REQ-013 rx_ready  output  1  RX byte consumed this cycle.
REQ-014 tx_valid  output  1  TX FIFO non-empty.
REQ-015 tx_data  output  8  TX FIFO head byte.
REQ-016 tx_ready  input  1  UART TX accepts head byte.
REQ-017 program_done  output  1  sticky; program stop written.

Function
REQ-018 Request accepted in a cycle iff rdy_in=1; with rdy_in=0 no RAM/IO access, mem_din holds, counter holds.
REQ-019 Decode: mem_a[17:16]==2'b11 -> IO; else RAM at index mem_a[RAM_AW-1:0].
REQ-020 RAM write: mem_dout stored at clock edge of accepted write cycle; no wait states.
REQ-021 RAM read: mem_din = RAM[addr] registered, valid exactly one cycle after the request cycle; read-after-write to same address in next cycle returns new data.
REQ-022 mem_din holds last returned value in cycles with no accepted read.
REQ-023 Read 0x30000: if rx_valid, mem_din <= rx_data and rx_ready=1 (combinational, same cycle); else mem_din <= 0x00, rx_ready=0.
REQ-024 Write 0x30000: mem_dout!=0x00 pushed to TX FIFO; 0x00 ignored; push while FIFO full and no pop is dropped.
REQ-025 Cycle counter: 32-bit, 0 at reset, +1 each cycle rdy_in=1, wraps 0xFFFFFFFF->0.
REQ-026 Read 0x30004: mem_din <= counter[7:0], full counter latched into snapshot same edge; reads 0x30005/6/7 return snapshot bytes 1/2/3 (little-endian).
REQ-027 Write 0x30004: push 0x00 into TX FIFO (bypassing zero filter), set program_done next cycle; remains 1 until reset.
REQ-028 Other IO addresses: read returns 0x00, write ignored.
REQ-029 TX FIFO: depth 2^TXQ_LOG, circular pointers wrap; tx_valid=!empty; tx_data=head; pop on tx_valid&tx_ready; drains regardless of rdy_in.
REQ-030 Simultaneous push and pop: both performed, count unchanged; when full, push accepted because pop frees slot same edge.
REQ-031 io_buffer_full=1 (registered) when free entries <= 2, giving CPU two cycles of margin.
REQ-032 rx_ready never asserted except for an accepted read of 0x30000.

Reset
REQ-033 On rst_in=1 at a clock edge: mem_din=0x00, FIFO empty, tx_valid=0, io_buffer_full=0, counter=0, snapshot=0, program_done=0; takes priority over any simultaneous request.
REQ-034 RAM contents are not cleared by reset; reset mid-transaction discards pending read data and queued TX bytes.

Verification
REQ-035 Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after read; rdy_in=0 during read cycle -> mem_din unchanged.
REQ-036 Write 0x41,0x00,0x42 to 0x30000, tx_ready=1 -> tx_data sequence 0x41,0x42 only.
REQ-037 tx_ready=0, write 14 bytes to 0x30000 (depth 16) -> io_buffer_full=1 after 14th; 17th push dropped; with tx_ready=1 on full FIFO plus push -> count stays 16.
REQ-038 rx_valid=1, rx_data=0x37, read 0x30000 -> rx_ready=1 that cycle, mem_din=0x37 next; rx_valid=0 -> mem_din=0x00.
REQ-039 After 300 rdy cycles read 0x30004..0x30007 -> bytes form snapshot 300 (0x2C,0x01,0x00,0x00) despite counter advancing.
REQ-040 Write 0x30004 -> tx_data 0x00 emitted, program_done=1; assert rst_in -> program_done=0, FIFO empty.
